cmd_seq_rx: RTL and testbench
=============================

// Module: cmd_seq_rx
// PURPOSE
//  Downstream receiver for the command sequencer's serial output.
//  - Samples CMD_DATA under CMD_START_FLAG/CMD_READY framing and deserializes it MSB-first into WORD_WIDTH-bit words.
//  - Buffers words in a FIFO with per-word frame-end/bit-count tags and presents them on a valid/ready interface.
//  - Loopback checker on the command path and front end of emulated-chip decoders; runs in the command clock domain.
// PARAMETERS
//  WORD_WIDTH  8   bits per output word (>=2)
//  FIFO_DEPTH  16  FIFO entries (power of 2, >=2)
// PORTS
//  BUS_CLK         in   1    single clock (command clock domain); all logic on rising edge
//  BUS_RST_N       in   1    reset, synchronous, active-low
//  CMD_DATA        in   1    serial command bit, sampled every cycle in-frame
//  CMD_START_FLAG  in   1    1-cycle pulse; first bit of frame on CMD_DATA in same cycle
//  CMD_READY       in   1    high = sequencer idle; first high cycle after a frame ends it
//  WORD_DATA       out  WORD_WIDTH  head word, MSB = first received bit, unused LSBs zero
//  WORD_NBITS      out  $clog2(WORD_WIDTH+1)  valid bits in WORD_DATA (0..WORD_WIDTH)
//  WORD_LAST       out  1    head word ends its frame
//  WORD_VALID      out  1    FIFO non-empty
//  WORD_READY      in   1    consumer accepts head word when WORD_VALID&WORD_READY
//  FRAME_CNT       out  16   completed frames, wraps 0xFFFF->0
//  DROP_CNT        out  8    words dropped on full FIFO, saturates at 0xFF
//  OVERFLOW        out  1    sticky: set on first drop, cleared only by reset
// BEHAVIOUR
//  Reset (BUS_RST_N=0 at edge): state IDLE; shift reg, bit count, FIFO pointers and count cleared.
//   All outputs 0: WORD_VALID, WORD_DATA, WORD_NBITS, WORD_LAST, FRAME_CNT, DROP_CNT, OVERFLOW.
//   Reset mid-frame discards the partial word and all FIFO contents; no LAST entry is produced.
//  FSM IDLE:
//   - CMD_START_FLAG=1: capture bit 0 of the frame, go SHIFT.
//   - CMD_START_FLAG=0: ignore CMD_DATA.
//  FSM SHIFT, evaluated in priority order:
//   1. CMD_READY=1: end of frame, no bit captured. Push {shreg left-aligned, zero-padded; NBITS=bit_cnt; LAST=1}.
//      If bit_cnt==0 (ended on a word boundary), push a 0-bit entry {DATA=0, NBITS=0, LAST=1}.
//      FRAME_CNT+1, go IDLE. A START_FLAG in the same cycle is ignored.
//   2. CMD_START_FLAG=1: close the current frame exactly as in 1 (FRAME_CNT+1), then capture bit 0 of the new frame.
//      Stay SHIFT; the closing push and the new capture happen in the same cycle.
//   3. Otherwise: capture bit; shreg={shreg,CMD_DATA}, bit_cnt+1.
//  Word push: when a capture makes bit_cnt reach WORD_WIDTH, push {word, NBITS=WORD_WIDTH, LAST=0}
//   in the same edge as the capture; bit_cnt returns to 0.
//  Latency: word completed or closed at edge N -> WORD_VALID=1 with that word at head from edge N on (1 cycle).
//  FIFO: head entry is driven combinationally from memory; WORD_VALID = (count!=0).
//   - Pop on WORD_VALID&WORD_READY.
//   - Push when full and no pop in the same cycle: entry dropped; DROP_CNT+1 (saturating), OVERFLOW<=1.
//   - Push and pop in the same cycle when full: both take effect, nothing dropped.
//   - Pop when empty: no effect.
//   - Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
//  Dropped words still advance framing; bit alignment is never lost on overflow.
//  WORD_DATA, WORD_NBITS and WORD_LAST stay stable while WORD_VALID=1 and WORD_READY=0.
// TESTING
//  1. Frame 0xA5,0x3C (16 bits), READY=1 after, WORD_READY=1 ->
//     words {A5,8,0}, {3C,8,0}, {00,0,1}; FRAME_CNT=1.
//  2. 11-bit frame 101_1001_1101 -> words {B3,8,0}, {A0,3,1}
//     (second word = bits 101 left-aligned, zero-padded).
//  3. WORD_READY=0, frames totalling 20 words (WORD_WIDTH=8, FIFO_DEPTH=16) -> 16 stored, DROP_CNT=4, OVERFLOW=1.
//     Then WORD_READY=1 drains 16 entries in order.
//  4. FIFO full, push and pop in the same cycle -> count stays 16, DROP_CNT unchanged.
//  5. START_FLAG mid-frame after 5 bits 11010 -> {D0,5,1}, then new frame bits start at MSB; FRAME_CNT+1.
//  6. BUS_RST_N=0 for 1 cycle mid-frame with 3 words queued -> WORD_VALID=0, all counters 0.
//     Next frame decodes correctly from bit 0.

Source files
------------

// File: rtl/cmd_seq_rx.sv
// Serial command receiver: MSB-first deserializer feeding a tagged word FIFO.
// Frame ends on CMD_READY or a new CMD_START_FLAG; words carry NBITS/LAST tags.
module cmd_seq_rx #(
    parameter int WORD_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int NBW = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST_N,
    input  logic                  CMD_DATA,
    input  logic                  CMD_START_FLAG,
    input  logic                  CMD_READY,
    output logic [WORD_WIDTH-1:0] WORD_DATA,
    output logic [NBW-1:0]        WORD_NBITS,
    output logic                  WORD_LAST,
    output logic                  WORD_VALID,
    input  logic                  WORD_READY,
    output logic [15:0]           FRAME_CNT,
    output logic [7:0]            DROP_CNT,
    output logic                  OVERFLOW
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int SHW = NBW + 1;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t                r_state;
    logic [WORD_WIDTH-1:0] r_shreg;
    logic [NBW-1:0]        r_bcnt;
    logic [15:0]           r_frame_cnt;

    logic [WORD_WIDTH-1:0] r_mem_d [FIFO_DEPTH];
    logic [NBW-1:0]        r_mem_n [FIFO_DEPTH];
    logic                  r_mem_l [FIFO_DEPTH];
    logic [AW-1:0]         r_wp;
    logic [AW-1:0]         r_rp;
    logic [CW-1:0]         r_cnt;
    logic [7:0]            r_drop;
    logic                  r_ovf;

    logic                  w_close;
    logic                  w_word_done;
    logic                  w_push;
    logic [WORD_WIDTH-1:0] w_pdata;
    logic [NBW-1:0]        w_pnbits;
    logic                  w_plast;
    logic [SHW-1:0]        w_sh;
    logic [WORD_WIDTH-1:0] w_align;
    logic [WORD_WIDTH-1:0] w_shift;
    logic                  w_valid;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_drop;

    // Stale upper bits of the shift register fall off the top here.
    assign w_sh    = SHW'(WORD_WIDTH) - SHW'(r_bcnt);
    assign w_align = r_shreg << w_sh;
    assign w_shift = {r_shreg[WORD_WIDTH-2:0], CMD_DATA};

    assign w_close     = (r_state == S_SHIFT) &&
                         (CMD_READY || CMD_START_FLAG);
    assign w_word_done = (r_state == S_SHIFT) && !CMD_READY &&
                         !CMD_START_FLAG &&
                         (r_bcnt == NBW'(WORD_WIDTH - 1));

    always_comb begin
        w_push   = 1'b0;
        w_pdata  = '0;
        w_pnbits = '0;
        w_plast  = 1'b0;
        if (w_close) begin
            w_push   = 1'b1;
            w_pdata  = w_align;
            w_pnbits = r_bcnt;
            w_plast  = 1'b1;
        end else if (w_word_done) begin
            w_push   = 1'b1;
            w_pdata  = w_shift;
            w_pnbits = NBW'(WORD_WIDTH);
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_bcnt      <= '0;
            r_frame_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (CMD_START_FLAG) begin
                        r_shreg <= w_shift;
                        r_bcnt  <= NBW'(1);
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (CMD_READY) begin
                        r_bcnt      <= '0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= S_IDLE;
                    end else if (CMD_START_FLAG) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_shreg     <= w_shift;
                        r_bcnt      <= NBW'(1);
                    end else begin
                        r_shreg <= w_shift;
                        r_bcnt  <= w_word_done ? '0 : r_bcnt + NBW'(1);
                    end
                end
            endcase
        end
    end

    assign w_valid = (r_cnt != '0);
    assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
    assign w_pop   = w_valid && WORD_READY;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge BUS_CLK) begin
        if (w_wr) begin
            r_mem_d[r_wp] <= w_pdata;
            r_mem_n[r_wp] <= w_pnbits;
            r_mem_l[r_wp] <= w_plast;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_drop <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            if (w_wr && !w_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (!w_wr && w_pop) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop != 8'hFF) begin
                    r_drop <= r_drop + 8'd1;
                end
            end
        end
    end

    assign WORD_VALID = w_valid;
    assign WORD_DATA  = w_valid ? r_mem_d[r_rp] : '0;
    assign WORD_NBITS = w_valid ? r_mem_n[r_rp] : '0;
    assign WORD_LAST  = w_valid ? r_mem_l[r_rp] : 1'b0;
    assign FRAME_CNT  = r_frame_cnt;
    assign DROP_CNT   = r_drop;
    assign OVERFLOW   = r_ovf;

endmodule

// File: tb/tb_cmd_seq_rx.sv
// Directed bench for cmd_seq_rx with a queue of expected words.
// Expected entries are queued as bits are driven and checked on each pop.
module tb_cmd_seq_rx;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int NB = 4;

    typedef logic [W+NB:0] ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_data;
    logic          cmd_start;
    logic          cmd_ready;
    logic [W-1:0]  word_data;
    logic [NB-1:0] word_nbits;
    logic          word_last;
    logic          word_valid;
    logic          word_ready;
    logic [15:0]   frame_cnt;
    logic [7:0]    drop_cnt;
    logic          overflow;

    always #5 clk = ~clk;

    cmd_seq_rx #(.WORD_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .BUS_CLK       (clk),
        .BUS_RST_N     (rst_n),
        .CMD_DATA      (cmd_data),
        .CMD_START_FLAG(cmd_start),
        .CMD_READY     (cmd_ready),
        .WORD_DATA     (word_data),
        .WORD_NBITS    (word_nbits),
        .WORD_LAST     (word_last),
        .WORD_VALID    (word_valid),
        .WORD_READY    (word_ready),
        .FRAME_CNT     (frame_cnt),
        .DROP_CNT      (drop_cnt),
        .OVERFLOW      (overflow)
    );

    ent_t       q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         exp_frames = 0;
    int         exp_drop = 0;
    logic       exp_ovf = 1'b0;
    logic [7:0] acc;
    int         k;
    bit         pend = 1'b0;
    ent_t       head;
    ent_t       prev_head;
    bit         prev_hold = 1'b0;

    assign head = {word_data, word_nbits, word_last};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void exp_push(input logic [7:0] d,
                                     input logic [3:0] nb,
                                     input logic l);
        if (q.size() == D && !word_ready) begin
            if (exp_drop < 255) exp_drop++;
            exp_ovf = 1'b1;
        end else begin
            q.push_back({d, nb, l});
        end
    endfunction

    task automatic step(input logic s, input logic d, input logic r);
        cmd_start = s;
        cmd_data  = d;
        cmd_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'b1);
    endtask

    function automatic void close_entry();
        logic [7:0] d;
        d = (k == 0) ? 8'h00 : 8'(acc << (8 - k));
        exp_push(d, 4'(k), 1'b1);
        exp_frames++;
        pend = 1'b0;
    endfunction

    task automatic close_frame();
        close_entry();
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic send_frame(input logic [159:0] bits, input int n,
                              input bit end_rdy, input int rdy_at);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = bits[n-1-i];
            if (i == rdy_at) word_ready = 1'b1;
            if (i == 0 && pend) close_entry();
            if (i == 0) begin
                acc = 8'h00;
                k   = 0;
            end
            acc = {acc[6:0], b};
            k++;
            if (k == 8) begin
                exp_push(acc, 4'd8, 1'b0);
                k = 0;
            end
            step(i == 0, b, 1'b0);
        end
        pend = 1'b1;
        if (end_rdy) close_frame();
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold && word_valid) chk("hold", head, prev_head);
            if (word_valid && word_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_word", q.size(), 1);
                end else begin
                    chk("word", head, q[0]);
                    void'(q.pop_front());
                end
            end
            prev_hold = word_valid && !word_ready;
            prev_head = head;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [159:0] big;
        rst_n      = 1'b0;
        word_ready = 1'b0;
        cmd_start  = 1'b0;
        cmd_data   = 1'b0;
        cmd_ready  = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        chk("rst_valid", word_valid, 0);
        chk("rst_data", word_data, 0);
        chk("rst_nbits", word_nbits, 0);
        chk("rst_last", word_last, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_ovf", overflow, 0);

        word_ready = 1'b1;
        send_frame(160'hA53C, 16, 1, -1);
        idle(3);
        wait_drain("t1_drain");
        chk("t1_frame", frame_cnt, 1);

        send_frame(160'h59D, 11, 1, -1);
        idle(3);
        wait_drain("t2_drain");
        chk("t2_frame", frame_cnt, exp_frames);

        word_ready = 1'b0;
        big = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        send_frame(big, 152, 1, -1);
        idle(2);
        chk("t3_drop", drop_cnt, 4);
        chk("t3_ovf", overflow, 1);
        chk("t3_valid", word_valid, 1);

        send_frame(160'h96, 8, 0, 7);
        chk("t4_drop", drop_cnt, 4);
        chk("t4_valid", word_valid, 1);
        close_frame();
        wait_drain("t4_drain");
        chk("t4_drop_after", drop_cnt, exp_drop);
        chk("t4_ovf", overflow, exp_ovf);
        chk("t4_frame", frame_cnt, exp_frames);

        send_frame(160'h1A, 5, 0, -1);
        send_frame(160'hF0F, 12, 1, -1);
        idle(2);
        wait_drain("t5_drain");
        chk("t5_frame", frame_cnt, exp_frames);

        word_ready = 1'b0;
        big = {128'h0, $urandom()};
        send_frame(big, 27, 0, -1);
        chk("t6_queued", word_valid, 1);
        rst_n = 1'b0;
        q.delete();
        pend       = 1'b0;
        exp_frames = 0;
        exp_drop   = 0;
        exp_ovf    = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        chk("t6_valid", word_valid, 0);
        chk("t6_data", word_data, 0);
        chk("t6_frame", frame_cnt, 0);
        chk("t6_drop", drop_cnt, 0);
        chk("t6_ovf", overflow, 0);
        step(1'b0, 1'b0, 1'b1);
        word_ready = 1'b1;
        send_frame(160'hC35A, 16, 1, -1);
        idle(3);
        wait_drain("t6_drain");
        chk("t6_frame_after", frame_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
